calc_frame_engine: RTL and testbench

- Byte-level calculator core. Sits directly downstream of the UART receiver and directly upstream of the UART transmitter.
- Assembles each 3-byte frame (operand A, operator ASCII, operand B), computes an 8-bit result, and hands the result byte to the UART TX with a start/busy handshake.
- Implements the protocol exercised by the calculator benches: 5 '+' 10 -> 15, 15 '/' 0 -> divide-by-zero.

---
 rtl/calc_pkg.sv | 28 ++
 rtl/calc_div8.sv | 65 ++++++
 rtl/calc_frame_engine.sv | 169 ++++++++++++++++
 tb/tb_calc_frame_engine.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared constants and types for the byte-level calculator frame engine.
// Operator bytes are the ASCII codes seen on the UART link.
package calc_pkg;

  localparam logic [7:0] OP_ADD      = 8'h2B;  // '+'
  localparam logic [7:0] OP_SUB      = 8'h2D;  // '-'
  localparam logic [7:0] OP_MUL_X    = 8'h78;  // 'x'
  localparam logic [7:0] OP_MUL_STAR = 8'h2A;  // '*'
  localparam logic [7:0] OP_DIV      = 8'h2F;  // '/'

  localparam logic [7:0] DIV0_CODE_DFLT = 8'hFF;

  typedef enum logic [2:0] {
    StIdle,
    StGetOp,
    StGetB,
    StExec,
    StDiv,
    StSend,
    StWaitTx
  } state_e;

  function automatic logic is_op(input logic [7:0] b);
    return (b == OP_ADD) || (b == OP_SUB) || (b == OP_MUL_X) ||
           (b == OP_MUL_STAR) || (b == OP_DIV);
  endfunction

endpackage

// File: rtl/calc_div8.sv
// Iterative 8-bit restoring divider: one quotient bit per clock, the first bit
// is resolved on the start edge, so done pulses 8 cycles after start.
module calc_div8 (
  input  logic       CLK,
  input  logic       RST,
  input  logic       start,
  input  logic [7:0] dividend,
  input  logic [7:0] divisor,
  output logic       busy,
  output logic       done,
  output logic [7:0] quotient
);

  logic [7:0] rem_q, quo_q, dsr_q;
  logic [2:0] cnt_q;
  logic [7:0] rem_in, work_in, dsr_in, rem_nx, quo_nx;
  logic [8:0] shifted, diff;

  // quo_q shifts the remaining dividend bits out and quotient bits in
  always_comb begin
    rem_in  = start ? 8'h00 : rem_q;
    work_in = start ? dividend : quo_q;
    dsr_in  = start ? divisor : dsr_q;
    shifted = {rem_in, work_in[7]};
    diff    = shifted - {1'b0, dsr_in};
    if (!diff[8]) begin
      rem_nx = diff[7:0];
      quo_nx = {work_in[6:0], 1'b1};
    end else begin
      rem_nx = shifted[7:0];
      quo_nx = {work_in[6:0], 1'b0};
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rem_q <= 8'h00;
      quo_q <= 8'h00;
      dsr_q <= 8'h00;
      cnt_q <= 3'd0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        rem_q <= rem_nx;
        quo_q <= quo_nx;
        dsr_q <= divisor;
        cnt_q <= 3'd1;
        busy  <= 1'b1;
      end else if (busy) begin
        rem_q <= rem_nx;
        quo_q <= quo_nx;
        cnt_q <= cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  assign quotient = quo_q;

endmodule

// File: rtl/calc_frame_engine.sv
// Calculator frame engine: collects A, operator, B from the UART RX, computes an
// 8-bit result and hands it to the UART TX with a start/busy handshake.
module calc_frame_engine
  import calc_pkg::*;
#(
  parameter int unsigned CLK_FREQ      = 50000000,
  parameter int unsigned BAUD          = 9600,
  parameter int unsigned TIMEOUT_BYTES = 30,
  parameter logic [7:0]  DIV0_CODE     = DIV0_CODE_DFLT
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       E,
  input  logic [7:0] RX_DATA,
  input  logic       RX_VALID,
  input  logic       TX_BUSY,
  output logic [7:0] TX_DATA,
  output logic       TX_START,
  output logic       DIV0,
  output logic       FRAME_ERR,
  output logic       RX_DROP
);

  localparam int unsigned TMO_CLKS = CLK_FREQ / BAUD * 10 * TIMEOUT_BYTES;
  localparam int unsigned TMO_W    = (TMO_CLKS > 1) ? $clog2(TMO_CLKS) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CLKS - 1);

  state_e           state_q;
  logic [7:0]       a_q, b_q, op_q, result_q;
  logic [TMO_W-1:0] tmo_q;
  logic [1:0]       wcnt_q;
  logic             seen_q;

  logic       div_start, div_busy, div_done;
  logic [7:0] div_quo;

  assign div_start = (state_q == StExec) && E && (op_q == OP_DIV) && (b_q != 8'h00);

  calc_div8 u_div (
    .CLK      (CLK),
    .RST      (RST),
    .start    (div_start),
    .dividend (a_q),
    .divisor  (b_q),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_quo)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= StIdle;
      a_q       <= 8'h00;
      b_q       <= 8'h00;
      op_q      <= 8'h00;
      result_q  <= 8'h00;
      tmo_q     <= '0;
      wcnt_q    <= 2'd0;
      seen_q    <= 1'b0;
      TX_DATA   <= 8'h00;
      TX_START  <= 1'b0;
      DIV0      <= 1'b0;
      FRAME_ERR <= 1'b0;
      RX_DROP   <= 1'b0;
    end else begin
      TX_START  <= 1'b0;
      FRAME_ERR <= 1'b0;
      RX_DROP   <= 1'b0;
      // Once a result is committed to the TX, disable no longer aborts
      if (!E && (state_q != StSend) && (state_q != StWaitTx)) begin
        state_q <= StIdle;
        tmo_q   <= '0;
      end else begin
        case (state_q)
          StIdle: begin
            if (RX_VALID) begin
              a_q     <= RX_DATA;
              DIV0    <= 1'b0;
              tmo_q   <= '0;
              state_q <= StGetOp;
            end
          end
          StGetOp: begin
            if (RX_VALID) begin
              tmo_q <= '0;
              if (is_op(RX_DATA)) begin
                op_q    <= RX_DATA;
                state_q <= StGetB;
              end else begin
                FRAME_ERR <= 1'b1;
                state_q   <= StIdle;
              end
            end else if (tmo_q == TMO_LAST) begin
              FRAME_ERR <= 1'b1;
              tmo_q     <= '0;
              state_q   <= StIdle;
            end else begin
              tmo_q <= tmo_q + TMO_W'(1);
            end
          end
          StGetB: begin
            if (RX_VALID) begin
              b_q     <= RX_DATA;
              tmo_q   <= '0;
              state_q <= StExec;
            end else if (tmo_q == TMO_LAST) begin
              FRAME_ERR <= 1'b1;
              tmo_q     <= '0;
              state_q   <= StIdle;
            end else begin
              tmo_q <= tmo_q + TMO_W'(1);
            end
          end
          StExec: begin
            RX_DROP <= RX_VALID;
            state_q <= StSend;
            case (op_q)
              OP_ADD:                result_q <= a_q + b_q;
              OP_SUB:                result_q <= a_q - b_q;
              OP_MUL_X, OP_MUL_STAR: result_q <= a_q * b_q;
              default: begin
                if (b_q == 8'h00) begin
                  result_q <= DIV0_CODE;
                  DIV0     <= 1'b1;
                end else begin
                  state_q <= StDiv;
                end
              end
            endcase
          end
          StDiv: begin
            RX_DROP <= RX_VALID;
            if (div_done) begin
              result_q <= div_quo;
              state_q  <= StSend;
            end else if (!div_busy) begin
              // Defensive: divider idle without a done means it was never started
              state_q <= StIdle;
            end
          end
          StSend: begin
            RX_DROP <= RX_VALID;
            if (!TX_BUSY) begin
              TX_DATA  <= result_q;
              TX_START <= 1'b1;
              wcnt_q   <= 2'd0;
              seen_q   <= 1'b0;
              state_q  <= StWaitTx;
            end
          end
          StWaitTx: begin
            RX_DROP <= RX_VALID;
            if (seen_q) begin
              if (!TX_BUSY) state_q <= StIdle;
            end else if (TX_BUSY) begin
              seen_q <= 1'b1;
            end else if (wcnt_q == 2'd3) begin
              state_q <= StIdle;
            end else begin
              wcnt_q <= wcnt_q + 2'd1;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_calc_frame_engine.sv
// Directed bench for calc_frame_engine with hand-computed results; timeout is
// shrunk to 200 clocks (1000 Hz / 100 baud * 10 * 2 bytes).
module tb_calc_frame_engine;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       e = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       tx_busy = 1'b0;
  logic [7:0] tx_data;
  logic       tx_start, div0, frame_err, rx_drop;

  int n_checks = 0;
  int n_pass = 0;
  int n_start = 0;
  int n_ferr = 0;
  int n_drop = 0;

  always #5 clk = ~clk;

  calc_frame_engine #(
    .CLK_FREQ      (1000),
    .BAUD          (100),
    .TIMEOUT_BYTES (2),
    .DIV0_CODE     (8'hFF)
  ) dut (
    .CLK       (clk),
    .RST       (rst_n),
    .E         (e),
    .RX_DATA   (rx_data),
    .RX_VALID  (rx_valid),
    .TX_BUSY   (tx_busy),
    .TX_DATA   (tx_data),
    .TX_START  (tx_start),
    .DIV0      (div0),
    .FRAME_ERR (frame_err),
    .RX_DROP   (rx_drop)
  );

  // Pulse counters sample the pre-edge value, so each one-cycle pulse counts once
  always @(posedge clk) begin
    if (tx_start)  n_start <= n_start + 1;
    if (frame_err) n_ferr  <= n_ferr + 1;
    if (rx_drop)   n_drop  <= n_drop + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  // Negedges from the caller's negedge until TX_START is seen; -1 if never
  task automatic wait_start(output int lat);
    int i;
    i   = 0;
    lat = -1;
    while (lat < 0 && i < 40) begin
      @(negedge clk);
      i++;
      if (tx_start) lat = i;
    end
  endtask

  task automatic run_frame(input string tag, input logic [7:0] a, input logic [7:0] op,
                           input logic [7:0] b, input int exp_lat, input logic [7:0] exp_data,
                           input logic exp_div0);
    int lat;
    send_byte(a);
    send_byte(op);
    send_byte(b);
    wait_start(lat);
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " data"}, 32'(tx_data), 32'(exp_data));
    check({tag, " div0"}, 32'(div0), 32'(exp_div0));
    tx_busy = 1'b1;
    repeat (3) @(negedge clk);
    check({tag, " hold"}, 32'(tx_data), 32'(exp_data));
    tx_busy = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: got no $finish, expected bench to complete");
    $fatal(1);
  end

  initial begin
    int s_start, s_ferr, s_drop, lat;

    #3 rst_n = 1'b0;
    #4;
    check("reset outputs", 32'({tx_data, tx_start, div0, frame_err, rx_drop}), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_frame("add 05+0A", 8'h05, 8'h2B, 8'h0A, 2, 8'h0F, 1'b0);
    run_frame("sub 1E-14", 8'h1E, 8'h2D, 8'h14, 2, 8'h0A, 1'b0);
    run_frame("mul 0Fx0A", 8'h0F, 8'h78, 8'h0A, 2, 8'h96, 1'b0);
    run_frame("sub wrap 14-1E", 8'h14, 8'h2D, 8'h1E, 2, 8'hF6, 1'b0);
    run_frame("mul 11*11", 8'h11, 8'h2A, 8'h11, 2, 8'h21, 1'b0);
    run_frame("add wrap F0+20", 8'hF0, 8'h2B, 8'h20, 2, 8'h10, 1'b0);
    run_frame("div 32/05", 8'h32, 8'h2F, 8'h05, 10, 8'h0A, 1'b0);
    run_frame("div FF/03", 8'hFF, 8'h2F, 8'h03, 10, 8'h55, 1'b0);
    run_frame("div 03/07", 8'h03, 8'h2F, 8'h07, 10, 8'h00, 1'b0);
    run_frame("div0 0F/00", 8'h0F, 8'h2F, 8'h00, 2, 8'hFF, 1'b1);
    check("div0 sticky in idle", 32'(div0), 32'd1);
    send_byte(8'h05);
    check("div0 cleared by A", 32'(div0), 32'd0);
    send_byte(8'h2B);
    send_byte(8'h01);
    wait_start(lat);
    check("after div0 data", 32'(tx_data), 32'h06);
    repeat (8) @(negedge clk);

    // Invalid operator
    s_start = n_start;
    s_ferr  = n_ferr;
    send_byte(8'h05);
    send_byte(8'h25);
    check("bad op frame_err", 32'(frame_err), 32'd1);
    repeat (6) @(negedge clk);
    check("bad op one pulse", 32'(n_ferr - s_ferr), 32'd1);
    check("bad op no tx", 32'(n_start - s_start), 32'd0);

    // Timeout after the operator byte
    send_byte(8'h05);
    send_byte(8'h2B);
    repeat (199) @(negedge clk);
    check("timeout not early", 32'(frame_err), 32'd0);
    @(negedge clk);
    check("timeout frame_err", 32'(frame_err), 32'd1);
    repeat (2) @(negedge clk);
    run_frame("post-timeout 01+01", 8'h01, 8'h2B, 8'h01, 2, 8'h02, 1'b0);

    // B byte arriving on the expiry cycle wins
    s_ferr = n_ferr;
    send_byte(8'h05);
    send_byte(8'h2B);
    repeat (198) @(negedge clk);
    send_byte(8'h07);
    wait_start(lat);
    check("edge byte latency", 32'(lat), 32'd2);
    check("edge byte data", 32'(tx_data), 32'h0C);
    repeat (8) @(negedge clk);
    check("edge byte no frame_err", 32'(n_ferr - s_ferr), 32'd0);

    // TX busy through SEND, byte dropped, start after busy falls, WAIT_TX times out
    tx_busy = 1'b1;
    s_start = n_start;
    s_drop  = n_drop;
    send_byte(8'h02);
    send_byte(8'h2B);
    send_byte(8'h03);
    send_byte(8'h77);
    check("busy rx_drop", 32'(rx_drop), 32'd1);
    repeat (5) @(negedge clk);
    check("busy no start", 32'(n_start - s_start), 32'd0);
    check("busy drop count", 32'(n_drop - s_drop), 32'd1);
    tx_busy = 1'b0;
    wait_start(lat);
    check("busy release latency", 32'(lat), 32'd1);
    check("busy data", 32'(tx_data), 32'h05);
    repeat (8) @(negedge clk);

    // Asynchronous reset in GET_B
    send_byte(8'h07);
    send_byte(8'h2B);
    #2 rst_n = 1'b0;
    #1;
    check("mid reset outputs", 32'({tx_data, tx_start, div0, frame_err, rx_drop}), 32'd0);
    @(negedge clk);
    rx_data  = 8'h09;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    rst_n    = 1'b1;
    run_frame("post-reset 01+02", 8'h01, 8'h2B, 8'h02, 2, 8'h03, 1'b0);

    // Disable after the operator byte
    send_byte(8'h09);
    send_byte(8'h2B);
    e = 1'b0;
    repeat (2) @(negedge clk);
    s_start = n_start;
    s_ferr  = n_ferr;
    s_drop  = n_drop;
    send_byte(8'h04);
    send_byte(8'h05);
    send_byte(8'h06);
    repeat (12) @(negedge clk);
    check("disabled no drop", 32'(n_drop - s_drop), 32'd0);
    check("disabled no start", 32'(n_start - s_start), 32'd0);
    check("disabled no frame_err", 32'(n_ferr - s_ferr), 32'd0);
    e = 1'b1;
    @(negedge clk);
    run_frame("re-enabled 01+01", 8'h01, 8'h2B, 8'h01, 2, 8'h02, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
